// File: rtl/vga_timing_pattern_gen.sv
// Programmable-timing VGA sync generator with four runtime test patterns.
// Single clock domain; pixel rate set by an internal clock-enable divider.
module vga_timing_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CLK_DIV  = 2,
    parameter int COLOR_W  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             mode,
    input  logic [3*COLOR_W-1:0]   fg_color,
    output logic [COLOR_W-1:0]     vga_r,
    output logic [COLOR_W-1:0]     vga_g,
    output logic [COLOR_W-1:0]     vga_b,
    output logic                   vga_hs,
    output logic                   vga_vs,
    output logic [9:0]             pixel_x,
    output logic [9:0]             pixel_y,
    output logic                   in_display,
    output logic                   frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] BAR_MAX  = 10'(H_ACTIVE / 8 - 1);
    localparam logic [9:0] STEP_MAX = 10'(H_ACTIVE / (2 ** COLOR_W) - 1);
    localparam logic       HS_ON    = 1'(HS_POL);
    localparam logic       VS_ON    = 1'(VS_POL);

    logic [DW-1:0]          r_div;
    logic [9:0]             r_hcount;
    logic [9:0]             r_vcount;
    logic [9:0]             r_bar_px;
    logic [2:0]             r_bar;
    logic [9:0]             r_step_px;
    logic [COLOR_W-1:0]     r_step;
    logic [1:0]             r_mode_q;
    logic [3*COLOR_W-1:0]   r_rgb;
    logic                   r_hs;
    logic                   r_vs;

    logic                   w_pix_tick;
    logic                   w_h_wrap;
    logic                   w_origin;
    logic                   w_frame_tick;
    logic                   w_in_disp;
    logic                   w_hs_act;
    logic                   w_vs_act;
    logic [1:0]             w_mode;
    logic [2:0]             w_bar_on;
    logic [3*COLOR_W-1:0]   w_rgb;

    assign w_pix_tick   = (r_div == DIV_MAX);
    assign w_h_wrap     = (r_hcount == H_MAX);
    assign w_origin     = (r_hcount == 10'd0) && (r_vcount == 10'd0);
    assign w_frame_tick = w_pix_tick && w_origin;
    assign w_in_disp    = (r_hcount < H_ACT) && (r_vcount < V_ACT);
    assign w_hs_act     = (r_hcount >= HS_BEG) && (r_hcount <= HS_END);
    assign w_vs_act     = (r_vcount >= VS_BEG) && (r_vcount <= VS_END);
    // The first pixel of a frame already uses the mode being latched.
    assign w_mode       = w_frame_tick ? mode : r_mode_q;
    // Bar index 0..7 maps to white, yellow, cyan, green, magenta, red, blue, black.
    assign w_bar_on     = {~r_bar[1], ~r_bar[2], ~r_bar[0]};

    always_comb begin
        w_rgb = '0;
        if (w_in_disp) begin
            case (w_mode)
                2'd0: w_rgb = fg_color;
                2'd1: w_rgb = {{COLOR_W{w_bar_on[2]}},
                               {COLOR_W{w_bar_on[1]}},
                               {COLOR_W{w_bar_on[0]}}};
                2'd2: w_rgb = (r_hcount[5] ^ r_vcount[5]) ? fg_color : '0;
                default: w_rgb = {r_step, r_step, r_step};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div     <= '0;
            r_hcount  <= '0;
            r_vcount  <= '0;
            r_bar_px  <= '0;
            r_bar     <= '0;
            r_step_px <= '0;
            r_step    <= '0;
            r_mode_q  <= '0;
            r_rgb     <= '0;
            r_hs      <= ~HS_ON;
            r_vs      <= ~VS_ON;
        end else begin
            if (w_pix_tick) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + DW'(1);
            end
            if (w_pix_tick) begin
                r_rgb <= w_rgb;
                r_hs  <= w_hs_act ? HS_ON : ~HS_ON;
                r_vs  <= w_vs_act ? VS_ON : ~VS_ON;
                if (w_origin) begin
                    r_mode_q <= mode;
                end
                if (w_h_wrap) begin
                    r_hcount  <= '0;
                    r_bar_px  <= '0;
                    r_bar     <= '0;
                    r_step_px <= '0;
                    r_step    <= '0;
                    r_vcount  <= (r_vcount == V_MAX) ? 10'd0
                                                     : r_vcount + 10'd1;
                end else begin
                    r_hcount <= r_hcount + 10'd1;
                    // Bar and ramp counters track hcount without a divider.
                    if (r_bar_px == BAR_MAX) begin
                        r_bar_px <= '0;
                        r_bar    <= r_bar + 3'd1;
                    end else begin
                        r_bar_px <= r_bar_px + 10'd1;
                    end
                    if (r_step_px == STEP_MAX) begin
                        r_step_px <= '0;
                        r_step    <= r_step + COLOR_W'(1);
                    end else begin
                        r_step_px <= r_step_px + 10'd1;
                    end
                end
            end
        end
    end

    assign vga_r       = r_rgb[3*COLOR_W-1:2*COLOR_W];
    assign vga_g       = r_rgb[2*COLOR_W-1:COLOR_W];
    assign vga_b       = r_rgb[COLOR_W-1:0];
    assign vga_hs      = r_hs;
    assign vga_vs      = r_vs;
    assign pixel_x     = r_hcount;
    assign pixel_y     = r_vcount;
    assign in_display  = w_in_disp;
    assign frame_start = w_frame_tick && !reset;

endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// Scoreboard bench: three timing configurations share stimulus;
// an independent pixel model predicts each registered output one tick ahead.
module tb_vga_timing_pattern_gen;

    localparam int HA[3]  = '{640, 8, 64};
    localparam int HF[3]  = '{16, 1, 4};
    localparam int HSW[3] = '{96, 2, 4};
    localparam int HB[3]  = '{48, 1, 8};
    localparam int VA[3]  = '{480, 4, 40};
    localparam int VF[3]  = '{10, 1, 2};
    localparam int VSW[3] = '{2, 1, 2};
    localparam int VB[3]  = '{33, 1, 2};
    localparam int HP[3]  = '{0, 1, 0};
    localparam int VP[3]  = '{0, 0, 0};
    localparam int DV[3]  = '{2, 1, 1};
    localparam int CW[3]  = '{4, 2, 4};

    logic        clk;
    logic        reset;
    logic [1:0]  mode;
    logic [11:0] fg;

    logic [3:0] r1, g1, b1, r3, g3, b3;
    logic [1:0] r2, g2, b2;
    logic       hs1, vs1, hs2, vs2, hs3, vs3;
    logic [9:0] px1, py1, px2, py2, px3, py3;
    logic       id1, id2, id3, fs1, fs2, fs3;

    int n_chk;
    int n_err;
    int sel;
    int mc;
    int mq;
    int fgm;
    logic [13:0] q[$];

    vga_timing_pattern_gen u1 (
        .clk(clk), .reset(reset), .mode(mode), .fg_color(fg),
        .vga_r(r1), .vga_g(g1), .vga_b(b1),
        .vga_hs(hs1), .vga_vs(vs1),
        .pixel_x(px1), .pixel_y(py1),
        .in_display(id1), .frame_start(fs1)
    );

    vga_timing_pattern_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(0), .CLK_DIV(1), .COLOR_W(2)
    ) u2 (
        .clk(clk), .reset(reset), .mode(mode), .fg_color(fg[5:0]),
        .vga_r(r2), .vga_g(g2), .vga_b(b2),
        .vga_hs(hs2), .vga_vs(vs2),
        .pixel_x(px2), .pixel_y(py2),
        .in_display(id2), .frame_start(fs2)
    );

    vga_timing_pattern_gen #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(4), .H_BP(8),
        .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .HS_POL(0), .VS_POL(0), .CLK_DIV(1), .COLOR_W(4)
    ) u3 (
        .clk(clk), .reset(reset), .mode(mode), .fg_color(fg),
        .vga_r(r3), .vga_g(g3), .vga_b(b3),
        .vga_hs(hs3), .vga_vs(vs3),
        .pixel_x(px3), .pixel_y(py3),
        .in_display(id3), .frame_start(fs3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int htot(input int s);
        return HA[s] + HF[s] + HSW[s] + HB[s];
    endfunction

    function automatic int vtot(input int s);
        return VA[s] + VF[s] + VSW[s] + VB[s];
    endfunction

    // Expected {R,G,B (4 bits each, zero-padded), hs, vs} for pixel t.
    function automatic logic [13:0] exp_out(input int s, input int t,
                                            input int md, input int f);
        int x, y, full, r, g, b, bar, st;
        logic hsa, vsa;
        x = t % htot(s);
        y = (t / htot(s)) % vtot(s);
        full = (1 << CW[s]) - 1;
        r = 0;
        g = 0;
        b = 0;
        if (x < HA[s] && y < VA[s]) begin
            case (md)
                0: begin
                    r = (f >> (2 * CW[s])) & full;
                    g = (f >> CW[s]) & full;
                    b = f & full;
                end
                1: begin
                    bar = x / (HA[s] / 8);
                    r = (bar == 0 || bar == 1 || bar == 4 || bar == 5)
                        ? full : 0;
                    g = (bar < 4) ? full : 0;
                    b = (bar % 2 == 0) ? full : 0;
                end
                2: begin
                    if ((((x >> 5) ^ (y >> 5)) & 1) == 1) begin
                        r = (f >> (2 * CW[s])) & full;
                        g = (f >> CW[s]) & full;
                        b = f & full;
                    end
                end
                default: begin
                    st = x / (HA[s] / (1 << CW[s]));
                    r = st;
                    g = st;
                    b = st;
                end
            endcase
        end
        hsa = (x >= HA[s] + HF[s]) && (x < HA[s] + HF[s] + HSW[s]);
        vsa = (y >= VA[s] + VF[s]) && (y < VA[s] + VF[s] + VSW[s]);
        return {4'(r), 4'(g), 4'(b),
                hsa ? (HP[s] != 0) : (HP[s] == 0),
                vsa ? (VP[s] != 0) : (VP[s] == 0)};
    endfunction

    task automatic sample(input int s, output logic [11:0] rgb,
                          output logic hs, output logic vs,
                          output int px, output int py, output logic fs);
        case (s)
            0: begin
                rgb = {r1, g1, b1};
                hs = hs1; vs = vs1;
                px = int'(px1); py = int'(py1); fs = fs1;
            end
            1: begin
                rgb = {2'b00, r2, 2'b00, g2, 2'b00, b2};
                hs = hs2; vs = vs2;
                px = int'(px2); py = int'(py2); fs = fs2;
            end
            default: begin
                rgb = {r3, g3, b3};
                hs = hs3; vs = vs3;
                px = int'(px3); py = int'(py3); fs = fs3;
            end
        endcase
    endtask

    task automatic restart(input int s, input int md, input int f);
        mode  = 2'(md);
        fg    = 12'(f);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        sel = s;
        fgm = f;
        mc  = 0;
        mq  = md;
        q.delete();
        q.push_back(exp_out(s, 0, mq, fgm));
    endtask

    task automatic run(input int n);
        logic [11:0] rgb;
        logic hs, vs, fs, efs;
        logic [13:0] e;
        int px, py, j, ht, vt, dv;
        ht = htot(sel);
        vt = vtot(sel);
        dv = DV[sel];
        repeat (n) begin
            @(posedge clk);
            #1;
            mc++;
            sample(sel, rgb, hs, vs, px, py, fs);
            j = mc / dv;
            if (mc % dv == 0) begin
                n_chk++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_empty dut=%0d tick=%0d", sel, j);
                end else begin
                    e = q.pop_front();
                    if ({rgb, hs, vs} !== e) begin
                        n_err++;
                        $display("FAIL sb_pix dut=%0d pix=%0d got %h exp %h",
                                 sel, j - 1, {rgb, hs, vs}, e);
                    end
                end
                n_chk++;
                if (px !== j % ht || py !== (j / ht) % vt) begin
                    n_err++;
                    $display("FAIL coord dut=%0d tick=%0d got %0d,%0d exp %0d,%0d",
                             sel, j, px, py, j % ht, (j / ht) % vt);
                end
                if (j % (ht * vt) == 0) mq = int'(mode);
                q.push_back(exp_out(sel, j, mq, fgm));
            end
            efs = ((mc + 1) % dv == 0) && (j % (ht * vt) == 0);
            n_chk++;
            if (fs !== efs) begin
                n_err++;
                $display("FAIL frame_start dut=%0d clk=%0d got %b exp %b",
                         sel, mc, fs, efs);
            end
        end
    endtask

    task automatic test_reset;
        logic [11:0] rgb;
        logic hs, vs, fs;
        int px, py;
        mode  = 2'd1;
        fg    = 12'hFFF;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sample(s, rgb, hs, vs, px, py, fs);
            n_chk++;
            if (rgb !== 12'h000 || fs !== 1'b0) begin
                n_err++;
                $display("FAIL reset_rgb_fs dut=%0d got %h/%b exp 000/0",
                         s, rgb, fs);
            end
            n_chk++;
            if (hs !== (HP[s] == 0) || vs !== (VP[s] == 0)) begin
                n_err++;
                $display("FAIL reset_sync dut=%0d got %b%b", s, hs, vs);
            end
            n_chk++;
            if (px !== 0 || py !== 0) begin
                n_err++;
                $display("FAIL reset_coord dut=%0d got %0d,%0d exp 0,0",
                         s, px, py);
            end
        end
    endtask

    task automatic test_solid;
        int hs_low, lit;
        restart(0, 0, 12'h34F);
        run(1700);
        hs_low = 0;
        lit = 0;
        repeat (1600) begin
            @(posedge clk);
            #1;
            if (hs1 == 1'b0) hs_low++;
            if ({r1, g1, b1} == 12'h34F) lit++;
        end
        n_chk++;
        if (hs_low !== 192) begin
            n_err++;
            $display("FAIL hs_low_clks got %0d exp 192", hs_low);
        end
        n_chk++;
        if (lit !== 1280) begin
            n_err++;
            $display("FAIL lit_clks got %0d exp 1280", lit);
        end
    endtask

    task automatic test_bars;
        restart(0, 1, 12'h000);
        run(1700);
    endtask

    task automatic test_ramp;
        restart(0, 3, 12'h000);
        run(1700);
    endtask

    task automatic test_checker;
        restart(2, 2, 12'h5A3);
        run(3780);
    endtask

    task automatic test_mode_switch;
        restart(2, 1, 12'h7C1);
        run(200);
        mode = 2'd0;
        run(3800);
    endtask

    task automatic test_small;
        restart(1, 0, 12'h02D);
        run(100);
    endtask

    task automatic test_reset_mid;
        restart(0, 0, 12'h34F);
        run(600);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        if (hs1 !== 1'b1 || {r1, g1, b1} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_mid_out got hs=%b rgb=%h exp 1/000",
                     hs1, {r1, g1, b1});
        end
        n_chk++;
        if (px1 !== 10'd0) begin
            n_err++;
            $display("FAIL reset_mid_x got %0d exp 0", px1);
        end
        reset = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        sel   = 0;
        mc    = 0;
        mq    = 0;
        fgm   = 0;
        reset = 1'b1;
        mode  = 2'd0;
        fg    = 12'h000;
        test_reset();
        test_solid();
        test_bars();
        test_ramp();
        test_checker();
        test_mode_switch();
        test_small();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
